// File: rtl/note_recorder.sv
// Records keypad notes into song memory as {note, duration} entries and ends each recording with a 12'h000 terminator.
// Optional NOTE_RECORDER_RESTS_EN: rest segments closed by a key press, or split at 63 beats, are also written.
module note_recorder #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  record_start,
  input  logic                  record_stop,
  input  logic                  beat,
  input  logic                  key_down,
  input  logic [5:0]            key_note,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [11:0]           wr_data,
  output logic                  recording,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] song_length
);

  localparam logic [ADDR_WIDTH-1:0] LAST_DATA = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [ADDR_WIDTH-1:0] TERM_ADDR = '1;
`ifdef NOTE_RECORDER_RESTS_EN
  localparam bit RESTS_EN = 1'b1;
`else
  localparam bit RESTS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, REC, FLUSH} state_t;

  state_t                  state;
  logic                    term_sent;
  logic                    key_q;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [5:0]              seg_note;
  logic [5:0]              seg_dur;

  logic                    seg_close;
  logic                    seg_write;
  logic [5:0]              next_note;
  logic [11:0]             entry;

  // A zero-beat segment still lasted at least one beat from the listener's view.
  function automatic logic [5:0] dur_floor1(input logic [5:0] d);
    return (d == 6'd0) ? 6'd1 : d;
  endfunction

  always_comb begin
    seg_close = record_stop || (key_down != key_q) ||
                (key_down && (key_note != seg_note)) ||
                (beat && (seg_dur == 6'd63));
    // A rest still open at stop time is always dropped.
    seg_write = record_stop ? (seg_note != 6'd0) : ((seg_note != 6'd0) || RESTS_EN);
    next_note = key_down ? key_note : 6'd0;
    entry     = {seg_note, dur_floor1(seg_dur)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      term_sent   <= 1'b0;
      key_q       <= 1'b0;
      addr        <= '0;
      seg_note    <= 6'd0;
      seg_dur     <= 6'd0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 12'h000;
      recording   <= 1'b0;
      full        <= 1'b0;
      song_length <= '0;
    end else begin
      wr_en <= 1'b0;
      key_q <= key_down;
      case (state)
        IDLE: begin
          if (record_start) begin
            full        <= 1'b0;
            song_length <= '0;
            addr        <= '0;
            state       <= ARMED;
          end
        end
        ARMED: begin
          if (record_stop) begin
            wr_en     <= 1'b1;
            wr_addr   <= addr;
            wr_data   <= 12'h000;
            term_sent <= 1'b1;
            recording <= 1'b1;
            state     <= FLUSH;
          end else if (key_down) begin
            seg_note  <= key_note;
            seg_dur   <= 6'd0;
            recording <= 1'b1;
            state     <= REC;
          end
        end
        REC: begin
          if (seg_close) begin
            if (seg_write) begin
              wr_en       <= 1'b1;
              wr_addr     <= addr;
              wr_data     <= entry;
              addr        <= addr + 1'b1;
              song_length <= song_length + 1'b1;
            end
            if (record_stop && !seg_write) begin
              wr_en     <= 1'b1;
              wr_addr   <= addr;
              wr_data   <= 12'h000;
              term_sent <= 1'b1;
              state     <= FLUSH;
            end else if (record_stop || (seg_write && (addr == LAST_DATA))) begin
              term_sent <= 1'b0;
              state     <= FLUSH;
            end
            seg_note <= next_note;
            seg_dur  <= beat ? 6'd1 : 6'd0;
          end else if (beat) begin
            seg_dur <= seg_dur + 6'd1;
          end
        end
        FLUSH: begin
          // Terminator goes out on the first FLUSH cycle; recording drops after it.
          if (!term_sent) begin
            wr_en     <= 1'b1;
            wr_addr   <= addr;
            wr_data   <= 12'h000;
            full      <= (addr == TERM_ADDR);
            term_sent <= 1'b1;
          end else begin
            recording <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Self-checking bench for note_recorder: directed scenarios plus random songs scored against a segment-level model.
module tb_note_recorder;

  localparam int AW  = 7;
  localparam int CAP = 1 << AW;
`ifdef NOTE_RECORDER_RESTS_EN
  localparam bit RESTS = 1'b1;
`else
  localparam bit RESTS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, record_start, record_start_s, record_stop, beat, key_down;
  logic [5:0]    key_note;
  logic          wr_en, recording, full;
  logic [AW-1:0] wr_addr, song_length;
  logic [11:0]   wr_data;
  logic          wr_en_s, recording_s, full_s;
  logic [1:0]    wr_addr_s, song_length_s;
  logic [11:0]   wr_data_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          got_addr[$];
  logic [11:0] got_data[$];
  int          got_cyc[$];
  int          got_addr_s[$];
  logic [11:0] got_data_s[$];

  int          ph_note[$];
  int          ph_beats[$];
  logic [11:0] exp_data[$];
  bit          exp_full;

  note_recorder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .record_start(record_start), .record_stop(record_stop),
    .beat(beat), .key_down(key_down), .key_note(key_note),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .recording(recording), .full(full), .song_length(song_length)
  );

  note_recorder #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .reset(reset), .record_start(record_start_s), .record_stop(record_stop),
    .beat(beat), .key_down(key_down), .key_note(key_note),
    .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .recording(recording_s), .full(full_s), .song_length(song_length_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(wr_data);
      got_cyc.push_back(cyc);
    end
    if (wr_en_s) begin
      got_addr_s.push_back(int'(wr_addr_s));
      got_data_s.push_back(wr_data_s);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_beat();
    repeat ($urandom_range(0, 2)) tick();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  // Each phase is a held note (or a rest) spanning a number of beats; long phases split into 63-beat pieces.
  function automatic void build_expected();
    int n;
    bit last;
    logic [5:0] nt;
    exp_data.delete();
    for (int i = 0; i < ph_note.size(); i++) begin
      last = (i == ph_note.size() - 1);
      n    = ph_beats[i];
      nt   = 6'(ph_note[i]);
      if (nt != 6'd0 || RESTS) begin
        while (n > 63) begin
          exp_data.push_back({nt, 6'd63});
          n -= 63;
        end
        if (!(last && nt == 6'd0))
          exp_data.push_back({nt, (n == 0) ? 6'd1 : 6'(n)});
      end
    end
    exp_full = (exp_data.size() >= CAP - 1);
    while (exp_data.size() > CAP - 1) void'(exp_data.pop_back());
  endfunction

  task automatic play_song(input string tag, input int pre_beats);
    int  stop_cyc;
    int  n;
    bit  last_note;
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    record_start = 1'b1;
    tick();
    record_start = 1'b0;
    for (int b = 0; b < pre_beats; b++) pulse_beat();
    for (int i = 0; i < ph_note.size(); i++) begin
      key_down = (ph_note[i] != 0);
      key_note = key_down ? 6'(ph_note[i]) : 6'($urandom_range(1, 63));
      tick();
      for (int b = 0; b < ph_beats[i]; b++) pulse_beat();
    end
    record_stop = 1'b1;
    tick();
    stop_cyc = cyc;
    record_stop = 1'b0;
    for (int k = 0; k < 8 && recording; k++) tick();
    check($sformatf("%s recording_low", tag), recording, 0);
    key_down = 1'b0;
    tick();
    build_expected();
    n = exp_data.size();
    check($sformatf("%s write_count", tag), got_data.size(), n + 1);
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check($sformatf("%s addr%0d", tag, i), got_addr[i], i);
      check($sformatf("%s data%0d", tag, i), got_data[i], exp_data[i]);
    end
    if (got_data.size() > n) begin
      check($sformatf("%s term_addr", tag), got_addr[n], n);
      check($sformatf("%s term_data", tag), got_data[n], 12'h000);
      last_note = (ph_note.size() > 0) && (ph_note[$] != 0);
      if (!exp_full)
        check($sformatf("%s term_cycle", tag), got_cyc[n], stop_cyc + (last_note ? 1 : 0));
    end
    check($sformatf("%s song_length", tag), song_length, n);
    check($sformatf("%s full", tag), full, exp_full);
  endtask

  initial begin
    int np, note, prev;
    reset = 1'b1; record_start = 1'b0; record_start_s = 1'b0; record_stop = 1'b0;
    beat = 1'b0; key_down = 1'b0; key_note = 6'd0;
    tick(); tick();
    check("reset wr_en", wr_en, 0);
    check("reset recording", recording, 0);
    check("reset full", full, 0);
    check("reset song_length", song_length, 0);
    check("reset wr_addr", wr_addr, 0);
    reset = 1'b0;
    tick();

    ph_note = '{12, 0}; ph_beats = '{5, 0};
    play_song("hold12", 2);

    ph_note = '{7, 0}; ph_beats = '{130, 0};
    play_song("hold7_cap", 0);

    ph_note = '{3, 0, 5}; ph_beats = '{2, 4, 1};
    play_song("rest_gap", 1);

    ph_note.delete(); ph_beats.delete();
    play_song("armed_stop", 1);

    // Note change with a coincident beat.
    got_data.delete(); got_addr.delete(); got_cyc.delete();
    record_start = 1'b1; tick(); record_start = 1'b0;
    key_down = 1'b1; key_note = 6'd9; tick();
    tick();
    key_note = 6'd10; beat = 1'b1; tick(); beat = 1'b0;
    check("chg wr_en", wr_en, 1);
    check("chg wr_data", wr_data, {6'd9, 6'd1});
    check("chg wr_addr", wr_addr, 0);
    pulse_beat(); pulse_beat();
    key_down = 1'b0; tick();
    check("chg2 wr_en", wr_en, 1);
    check("chg2 wr_data", wr_data, {6'd10, 6'd3});
    record_stop = 1'b1; tick(); record_stop = 1'b0;
    check("chg term wr_en", wr_en, 1);
    check("chg term wr_data", wr_data, 12'h000);
    check("chg term wr_addr", wr_addr, 2);
    check("chg term recording", recording, 1);
    tick();
    check("chg recording_low", recording, 0);
    check("chg song_length", song_length, 2);

    // Tiny memory fills after three entries.
    record_start_s = 1'b1; tick(); record_start_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_down = 1'b1; key_note = 6'(i + 1); tick(); tick();
      key_down = 1'b0; tick(); tick();
    end
    repeat (4) tick();
    check("small write_count", got_data_s.size(), 4);
    for (int i = 0; i < 3 && i < got_data_s.size(); i++) begin
      check($sformatf("small addr%0d", i), got_addr_s[i], i);
      check($sformatf("small data%0d", i), got_data_s[i], {6'(i + 1), 6'd1});
    end
    if (got_data_s.size() > 3) begin
      check("small term_addr", got_addr_s[3], 3);
      check("small term_data", got_data_s[3], 12'h000);
    end
    check("small full", full_s, 1);
    check("small recording", recording_s, 0);
    check("small song_length", song_length_s, 3);

    // Asynchronous reset in the middle of a recording.
    record_start = 1'b1; tick(); record_start = 1'b0;
    key_down = 1'b1; key_note = 6'd4; tick();
    key_note = 6'd5; tick();
    check("pre_reset wr_en", wr_en, 1);
    #2 reset = 1'b1;
    #1;
    check("async wr_en", wr_en, 0);
    check("async wr_data", wr_data, 0);
    check("async recording", recording, 0);
    check("async song_length", song_length, 0);
    key_down = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    ph_note = '{6, 0}; ph_beats = '{1, 0};
    play_song("after_reset", 0);

    for (int s = 0; s < 12; s++) begin
      ph_note.delete(); ph_beats.delete();
      np = $urandom_range(1, 6);
      prev = 0;
      for (int p = 0; p < np; p++) begin
        if (p > 0 && prev != 0 && ($urandom % 3) == 0) begin
          note = 0;
        end else begin
          note = $urandom_range(1, 63);
          if (note == prev) note = (note % 63) + 1;
        end
        ph_note.push_back(note);
        ph_beats.push_back((($urandom % 6) == 0) ? $urandom_range(60, 140) : $urandom_range(0, 8));
        prev = note;
      end
      play_song($sformatf("rand%0d", s), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
